// File: rtl/messbauer_spectrum_accumulator.sv
// Mossbauer spectrum accumulator: counts discriminator-accepted gamma events per velocity channel in a single-port RAM.
// Optional build macro MESSBAUER_SATURATION_EN makes bin increments saturate instead of wrapping.
module messbauer_spectrum_accumulator #(
   parameter  int CHANNEL_NUMBER = 512,
   parameter  int COUNTER_WIDTH  = 32,
   parameter  int WINDOW         = 8,
   localparam int ADDR_WIDTH     = $clog2(CHANNEL_NUMBER)
) (
   input  logic                     aclk,
   input  logic                     areset_n,
   input  logic                     acq_enable,
   input  logic                     clear,
   input  logic                     start,
   input  logic                     channel,
   input  logic                     lower_threshold,
   input  logic                     upper_threshold,
   input  logic                     rd_req,
   input  logic [ADDR_WIDTH-1:0]    rd_addr,
   output logic                     rd_valid,
   output logic [COUNTER_WIDTH-1:0] rd_data,
   output logic                     busy,
   output logic                     acquiring,
   output logic [31:0]              cycle_count,
   output logic                     sync_error
);

   localparam int WIN_W = $clog2(WINDOW + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_LOAD,
      S_ACQUIRE,
      S_CLEAR
   } state_t;

   state_t r_state, w_state_nxt;

   logic r_start_d, r_channel_d, r_lower_d, r_upper_d;
   logic w_start_edge, w_channel_edge, w_lower_edge, w_upper_edge;

   logic             r_win_open;
   logic [WIN_W-1:0] r_win_cnt;
   logic             w_accept;

   logic [ADDR_WIDTH-1:0]    r_index, r_clr_addr;
   logic [COUNTER_WIDTH-1:0] r_cur_cnt, r_ram_q;
   logic                     r_first, r_pend, r_rd_p1;

   logic                     w_wb, w_acc_now;
   logic [1:0]               w_inc;
   logic [COUNTER_WIDTH-1:0] w_base, w_next_cnt;
   logic [COUNTER_WIDTH:0]   w_sum_ext;

   logic                     w_ram_we, w_ram_re;
   logic [ADDR_WIDTH-1:0]    w_ram_addr;
   logic [COUNTER_WIDTH-1:0] w_ram_wdata;
   logic [COUNTER_WIDTH-1:0] r_mem [CHANNEL_NUMBER];

   assign w_start_edge   = start & ~r_start_d;
   assign w_channel_edge = channel & ~r_channel_d;
   assign w_lower_edge   = lower_threshold & ~r_lower_d;
   assign w_upper_edge   = upper_threshold & ~r_upper_d;

   // r_win_cnt holds the window cycle number of the current cycle; WINDOW+1 means it expired clean.
   assign w_accept = r_win_open && (r_win_cnt == WIN_W'(WINDOW + 1));

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         r_win_open <= 1'b0;
         r_win_cnt  <= '0;
      end else if (w_lower_edge) begin
         r_win_open <= ~w_upper_edge;
         r_win_cnt  <= WIN_W'(2);
      end else if (r_win_open) begin
         if (w_accept || w_upper_edge) r_win_open <= 1'b0;
         else                          r_win_cnt  <= r_win_cnt + WIN_W'(1);
      end
   end

   // Write-back happens in the ACQUIRE cycle that sees a channel/start edge or loses enable.
   assign w_wb      = (r_state == S_ACQUIRE) && (!acq_enable || w_start_edge || w_channel_edge);
   assign w_acc_now = (r_state == S_ACQUIRE) && !w_wb && w_accept;
   assign w_base    = r_first ? r_ram_q : r_cur_cnt;
   assign w_inc     = {1'b0, r_pend} + {1'b0, w_acc_now};
   assign w_sum_ext = {1'b0, w_base} + {{(COUNTER_WIDTH-1){1'b0}}, w_inc};

`ifdef MESSBAUER_SATURATION_EN
   assign w_next_cnt = w_sum_ext[COUNTER_WIDTH] ? '1 : w_sum_ext[COUNTER_WIDTH-1:0];
`else
   assign w_next_cnt = w_sum_ext[COUNTER_WIDTH-1:0];
`endif

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      acquiring   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clear)           w_state_nxt = S_CLEAR;
            else if (acq_enable) w_state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (!acq_enable)       w_state_nxt = S_IDLE;
            else if (w_start_edge) w_state_nxt = S_LOAD;
         end
         S_LOAD: w_state_nxt = S_ACQUIRE;
         S_ACQUIRE: begin
            acquiring = 1'b1;
            busy      = w_wb;
            if (!acq_enable)                         w_state_nxt = S_IDLE;
            else if (w_start_edge || w_channel_edge) w_state_nxt = S_LOAD;
         end
         S_CLEAR: begin
            busy = 1'b1;
            if (r_clr_addr == ADDR_WIDTH'(CHANNEL_NUMBER - 1)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Single RAM port shared by clear, bin load/write-back and host reads, arbitrated by state.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = r_index;
      w_ram_wdata = w_next_cnt;
      case (r_state)
         S_IDLE: begin
            w_ram_re   = rd_req;
            w_ram_addr = rd_addr;
         end
         S_LOAD:    w_ram_re = 1'b1;
         S_ACQUIRE: w_ram_we = w_wb;
         S_CLEAR: begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_addr;
            w_ram_wdata = '0;
         end
         default: ;
      endcase
   end

   // NOTE: the bin RAM has no reset; contents survive reset and are zeroed only by CLEAR.
   always_ff @(posedge aclk) begin
      if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
      if (w_ram_re) r_ram_q <= r_mem[w_ram_addr];
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         r_state     <= S_IDLE;
         r_start_d   <= 1'b0;
         r_channel_d <= 1'b0;
         r_lower_d   <= 1'b0;
         r_upper_d   <= 1'b0;
         r_index     <= '0;
         r_clr_addr  <= '0;
         r_cur_cnt   <= '0;
         r_first     <= 1'b0;
         r_pend      <= 1'b0;
         r_rd_p1     <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         cycle_count <= '0;
         sync_error  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_start_d   <= start;
         r_channel_d <= channel;
         r_lower_d   <= lower_threshold;
         r_upper_d   <= upper_threshold;
         r_rd_p1     <= (r_state == S_IDLE) && rd_req;
         rd_valid    <= r_rd_p1;
         if (r_rd_p1) rd_data <= r_ram_q;

         case (r_state)
            S_IDLE: begin
               r_pend  <= 1'b0;
               r_first <= 1'b0;
               if (clear) begin
                  r_clr_addr  <= '0;
                  cycle_count <= '0;
                  sync_error  <= 1'b0;
               end
            end
            S_ARMED: if (w_start_edge) r_index <= '0;
            S_LOAD: begin
               r_first <= 1'b1;
               r_pend  <= r_pend | w_accept;
            end
            S_ACQUIRE: begin
               r_first   <= 1'b0;
               r_cur_cnt <= w_next_cnt;
               r_pend    <= 1'b0;
               if (!acq_enable) begin
                  r_pend <= 1'b0;
               end else if (w_start_edge) begin
                  r_index     <= '0;
                  cycle_count <= cycle_count + 32'd1;
                  r_pend      <= w_accept;
               end else if (w_channel_edge) begin
                  // Out-of-range channel pulse: flag it and keep counting into the last bin.
                  if (r_index == ADDR_WIDTH'(CHANNEL_NUMBER - 1)) sync_error <= 1'b1;
                  else                                            r_index    <= r_index + ADDR_WIDTH'(1);
                  r_pend <= w_accept;
               end
            end
            S_CLEAR: r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_messbauer_spectrum_accumulator.sv
// Directed bench for messbauer_spectrum_accumulator; a 4-bit-counter instance shares all stimulus for the overflow case.
module tb_messbauer_spectrum_accumulator;

   localparam int WINDOW = 8;

   logic        aclk = 1'b0;
   logic        areset_n = 1'b0;
   logic        acq_enable = 1'b0, clear = 1'b0, start = 1'b0, channel = 1'b0;
   logic        lower_threshold = 1'b0, upper_threshold = 1'b0, rd_req = 1'b0;
   logic [8:0]  rd_addr = '0;

   logic        rd_valid, busy, acquiring, sync_error;
   logic [31:0] rd_data, cycle_count;

   logic        s_rd_valid, s_busy, s_acquiring, s_sync_error;
   logic [3:0]  s_rd_data;
   logic [31:0] s_cycle_count;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_small;
   int          busy_cycles;
   logic        saw_valid;

   always #5 aclk = ~aclk;

   messbauer_spectrum_accumulator #(.CHANNEL_NUMBER(512), .COUNTER_WIDTH(32), .WINDOW(WINDOW)) u_dut (
      .aclk(aclk), .areset_n(areset_n), .acq_enable(acq_enable), .clear(clear),
      .start(start), .channel(channel), .lower_threshold(lower_threshold),
      .upper_threshold(upper_threshold), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .acquiring(acquiring),
      .cycle_count(cycle_count), .sync_error(sync_error)
   );

   messbauer_spectrum_accumulator #(.CHANNEL_NUMBER(512), .COUNTER_WIDTH(4), .WINDOW(WINDOW)) u_dut_w4 (
      .aclk(aclk), .areset_n(areset_n), .acq_enable(acq_enable), .clear(clear),
      .start(start), .channel(channel), .lower_threshold(lower_threshold),
      .upper_threshold(upper_threshold), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(s_rd_valid), .rd_data(s_rd_data), .busy(s_busy), .acquiring(s_acquiring),
      .cycle_count(s_cycle_count), .sync_error(s_sync_error)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0; tick();
   endtask

   task automatic pulse_channel();
      channel = 1'b1; tick(); channel = 1'b0; tick();
   endtask

   // Lower edge with no upper edge: accepted once the window expires.
   task automatic good_event();
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;
      repeat (WINDOW + 1) tick();
   endtask

   task automatic arm();
      acq_enable = 1'b1; tick();
      pulse_start();
   endtask

   task automatic disarm();
      acq_enable = 1'b0; tick();
   endtask

   task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
      rd_addr = 9'(addr);
      rd_req  = 1'b1; tick(); rd_req = 1'b0;
      check({tag, "_early"}, {31'b0, rd_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
      check(tag, rd_data, exp);
      last_small = {28'b0, s_rd_data};
      tick();
   endtask

   task automatic do_clear(input string tag);
      clear = 1'b1; tick(); clear = 1'b0;
      busy_cycles = 0;
      while (busy && busy_cycles < 600) begin
         busy_cycles++;
         tick();
      end
      check(tag, busy_cycles, 32'd512);
   endtask

   initial begin
      // Reset
      repeat (3) tick();
      check("rst_rd_valid",   {31'b0, rd_valid},   32'd0);
      check("rst_rd_data",    rd_data,             32'd0);
      check("rst_busy",       {31'b0, busy},       32'd0);
      check("rst_acquiring",  {31'b0, acquiring},  32'd0);
      check("rst_cycle_cnt",  cycle_count,         32'd0);
      check("rst_sync_error", {31'b0, sync_error}, 32'd0);
      areset_n = 1'b1; tick();

      // T1: clear and read back
      do_clear("t1_busy_len");
      read_check("t1_bin0",   0,   32'd0);
      read_check("t1_bin255", 255, 32'd0);
      read_check("t1_bin511", 511, 32'd0);

      // T2: 3 events in bin0, 2 in bin1, start closes the cycle, then disable
      arm();
      check("t2_acquiring", {31'b0, acquiring}, 32'd1);
      repeat (3) good_event();
      pulse_channel();
      repeat (2) good_event();
      pulse_start();
      check("t2_cycle_cnt", cycle_count, 32'd1);
      acq_enable = 1'b0; #1;
      check("t2_wb_busy", {31'b0, busy}, 32'd1);
      tick();
      check("t2_acq_drop", {31'b0, acquiring}, 32'd0);
      check("t2_busy_drop", {31'b0, busy}, 32'd0);
      read_check("t2_bin0", 0, 32'd3);
      read_check("t2_bin1", 1, 32'd2);

      // T3: coincidence window
      arm();
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;
      repeat (2) tick();
      upper_threshold = 1'b1; tick(); upper_threshold = 1'b0;   // window cycle 4: reject
      repeat (10) tick();
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;
      repeat (6) tick();
      upper_threshold = 1'b1; tick(); upper_threshold = 1'b0;   // window cycle 8: reject
      repeat (10) tick();
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;
      repeat (8) tick();
      upper_threshold = 1'b1; tick(); upper_threshold = 1'b0;   // cycle 10: after accept
      repeat (3) tick();
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;
      tick();
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;   // pile-up: one count only
      repeat (10) tick();
      disarm();
      check("t3_cycle_cnt", cycle_count, 32'd1);
      read_check("t3_bin0", 0, 32'd5);

      // T4a: start and channel together -> back to bin0, cycle counted
      arm();
      pulse_channel();
      start = 1'b1; channel = 1'b1; tick();
      start = 1'b0; channel = 1'b0; tick();
      check("t4_cycle_cnt", cycle_count, 32'd2);
      good_event();
      disarm();
      read_check("t4_bin0", 0, 32'd6);
      read_check("t4_bin1", 1, 32'd2);

      // T4b: 512 channel edges without start
      arm();
      for (int i = 0; i < 512; i++) begin
         pulse_channel();
         if (i == 510) check("t4_sync_before", {31'b0, sync_error}, 32'd0);
      end
      check("t4_sync_after", {31'b0, sync_error}, 32'd1);
      repeat (2) good_event();
      disarm();
      check("t4_sync_sticky", {31'b0, sync_error}, 32'd1);
      read_check("t4_bin511", 511, 32'd2);
      read_check("t4_bin510", 510, 32'd0);

      // T5: pending event across LOAD; clear and read ignored while acquiring
      arm();
      clear = 1'b1; tick(); clear = 1'b0;
      check("t5_clear_ign", {31'b0, busy}, 32'd0);
      check("t5_still_acq", {31'b0, acquiring}, 32'd1);
      lower_threshold = 1'b1; tick(); lower_threshold = 1'b0;
      repeat (6) tick();
      channel = 1'b1; tick(); channel = 1'b0;   // accept lands in the LOAD cycle that follows
      tick(); tick();
      saw_valid = 1'b0;
      rd_addr = 9'd0;
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         saw_valid = saw_valid | rd_valid;
         tick();
      end
      check("t5_no_rd_valid", {31'b0, saw_valid}, 32'd0);
      disarm();
      read_check("t5_bin1", 1, 32'd3);
      read_check("t5_bin0", 0, 32'd6);

      // T6: counter overflow on the 4-bit instance
      do_clear("t6_busy_len");
      check("t6_cc_cleared",   cycle_count,         32'd0);
      check("t6_sync_cleared", {31'b0, sync_error}, 32'd0);
      arm();
      repeat (17) good_event();
      disarm();
      read_check("t6_bin0_w32", 0, 32'd17);
`ifdef MESSBAUER_SATURATION_EN
      check("t6_bin0_w4", last_small, 32'd15);
`else
      check("t6_bin0_w4", last_small, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
